key_prompter: RTL
=================

KEY_PROMPTER -- requirements
Module: key_prompter

Interface
REQ-001 Parameter SONG_LEN, default 8, number of notes in the built-in song; legal range 1..15.
REQ-002 Parameter NOTE_TIMEOUT, default 28'd100_000_000, per-note press window in clk cycles (1 s at 100 MHz); legal range >= 2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  starts or restarts the song; sampled every cycle.
REQ-006 correct_key_press  input  1  level from the key checker; high while the prompted key is held validly.
REQ-007 correct_key  output  4  key the player must press; 4'd0 = no key.
REQ-008 note_index  output  4  index of the current note, 0..SONG_LEN-1.
REQ-009 hit_count  output  4  notes completed by a correct press.
REQ-010 miss_count  output  4  notes skipped by timeout.
REQ-011 busy  output  1  high in PROMPT, RELEASE and ADVANCE.
REQ-012 done  output  1  high in DONE.

Function
REQ-013 Song ROM is combinational, indexed by note_index; entries 0..7 = 1,1,5,5,6,6,5,4; any index >= 8 returns 4'd0.
REQ-014 FSM states: IDLE, PROMPT, RELEASE, ADVANCE, DONE.
REQ-015 IDLE: correct_key = 0; start=1 -> PROMPT next cycle with note_index=0, hit_count=0, miss_count=0, timer=0.
REQ-016 PROMPT: correct_key = ROM[note_index]; timer increments by 1 each cycle.
REQ-017 PROMPT with correct_key_press=1 -> hit_count += 1, then RELEASE.
REQ-018 PROMPT with timer == NOTE_TIMEOUT-1 and correct_key_press=0 -> miss_count += 1, then ADVANCE.
REQ-019 Press and timeout in the same cycle count as a hit.
REQ-020 RELEASE: correct_key holds its value; stay until correct_key_press=0, then ADVANCE. No timeout applies in RELEASE.
REQ-021 ADVANCE (one cycle, correct_key = 0): if note_index == SONG_LEN-1 -> DONE; otherwise note_index += 1, timer = 0 -> PROMPT.
REQ-022 DONE: correct_key = 0; note_index, hit_count and miss_count hold; start=1 acts as in IDLE.
REQ-023 start is ignored in PROMPT, RELEASE and ADVANCE.
REQ-024 hit_count + miss_count == SONG_LEN on entry to DONE; the counters never wrap.
REQ-025 Timer is 28 bits wide and never exceeds NOTE_TIMEOUT-1.
REQ-026 All outputs are registered or decoded from registered state; no combinational path from any input to any output.

Reset
REQ-027 rst_n=0 forces immediately, regardless of state: IDLE, correct_key=0, note_index=0, hit_count=0, miss_count=0, timer=0, busy=0, done=0.
REQ-028 Reset asserted mid-song discards all progress; after release, the block waits in IDLE for start.

Configuration
REQ-029 Macro PROMPT_TIMEOUT_EN defined: timer and timeout skip behave per REQ-016, REQ-018 and REQ-019.
REQ-030 PROMPT_TIMEOUT_EN undefined: no timer logic; PROMPT waits indefinitely for correct_key_press; miss_count is constant 0.

Verification (NOTE_TIMEOUT=20, SONG_LEN=8, PROMPT_TIMEOUT_EN defined unless stated)
REQ-031 Reset, then start pulse -> next cycle: busy=1, correct_key=1, note_index=0.
REQ-032 Press 3 cycles then release, repeated for every prompt -> keys sequence 1,1,5,5,6,6,5,4; done=1 with hit_count=8 and miss_count=0.
REQ-033 Never press after start -> each note is skipped after 20 cycles; done=1 with miss_count=8.
REQ-034 Assert press exactly on the 20th PROMPT cycle of note 0 -> hit_count=1, miss_count=0.
REQ-035 Assert rst_n=0 at note_index=3 -> all outputs 0 and state IDLE; a new start begins at note 0.
REQ-036 PROMPT_TIMEOUT_EN undefined, no press for 1000 cycles -> note_index stays 0, correct_key=1, miss_count=0.

Source files
------------

// File: rtl/key_prompter.sv
// Song key prompter: steps through a built-in note ROM, counting hits and timed-out misses.
// Define PROMPT_TIMEOUT_EN to enable the per-note press window; otherwise PROMPT waits forever.
module key_prompter #(
  parameter int unsigned SONG_LEN     = 8,
  parameter logic [27:0] NOTE_TIMEOUT = 28'd100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       correct_key_press,
  output logic [3:0] correct_key,
  output logic [3:0] note_index,
  output logic [3:0] hit_count,
  output logic [3:0] miss_count,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StPrompt, StRelease, StAdvance, StDone} state_e;

  localparam logic [3:0] LastIdx = 4'(SONG_LEN - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] hit_q, hit_d;
  logic [3:0] rom_key;

  always_comb begin
    unique case (idx_q)
      4'd0:    rom_key = 4'd1;
      4'd1:    rom_key = 4'd1;
      4'd2:    rom_key = 4'd5;
      4'd3:    rom_key = 4'd5;
      4'd4:    rom_key = 4'd6;
      4'd5:    rom_key = 4'd6;
      4'd6:    rom_key = 4'd5;
      4'd7:    rom_key = 4'd4;
      default: rom_key = 4'd0;
    endcase
  end

`ifdef PROMPT_TIMEOUT_EN
  logic [27:0] timer_q, timer_d;
  logic [3:0]  miss_q, miss_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
`ifdef PROMPT_TIMEOUT_EN
    timer_d = timer_q;
    miss_d  = miss_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StPrompt;
          idx_d   = 4'd0;
          hit_d   = 4'd0;
`ifdef PROMPT_TIMEOUT_EN
          timer_d = 28'd0;
          miss_d  = 4'd0;
`endif
        end
      end
      StPrompt: begin
        // A press wins over a timeout landing in the same cycle.
        if (correct_key_press) begin
          hit_d   = hit_q + 4'd1;
          state_d = StRelease;
`ifdef PROMPT_TIMEOUT_EN
        end else if (timer_q == NOTE_TIMEOUT - 28'd1) begin
          miss_d  = miss_q + 4'd1;
          state_d = StAdvance;
        end else begin
          timer_d = timer_q + 28'd1;
`endif
        end
      end
      StRelease: begin
        if (!correct_key_press) state_d = StAdvance;
      end
      StAdvance: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StPrompt;
`ifdef PROMPT_TIMEOUT_EN
          timer_d = 28'd0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      hit_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
    end
  end

`ifdef PROMPT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= 28'd0;
      miss_q  <= 4'd0;
    end else begin
      timer_q <= timer_d;
      miss_q  <= miss_d;
    end
  end

  assign miss_count = miss_q;
`else
  assign miss_count = 4'd0;
`endif

  // Key stays visible through RELEASE since the index only moves in ADVANCE.
  assign correct_key = (state_q == StPrompt || state_q == StRelease) ? rom_key : 4'd0;
  assign note_index  = idx_q;
  assign hit_count   = hit_q;
  assign busy        = (state_q == StPrompt) || (state_q == StRelease) || (state_q == StAdvance);
  assign done        = (state_q == StDone);

endmodule
